pipe_hazard_ctl: RTL and testbench

PIPE_HAZARD_CTL -- requirements
Module: pipe_hazard_ctl

---
 rtl/pipe_hazard_ctl.sv | 158 +++++++++++++++
 tb/tb_pipe_hazard_ctl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard controller: load-use stall, slow-memory wait with timeout, branch flush.
// Optional stall performance counter enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctl (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs_top,
    input  logic [4:0]  id_rs_bot,
    input  logic        id_uses_top,
    input  logic        id_uses_bot,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_wen,
    input  logic        ex_is_load,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        pc_hold,
    output logic        if_id_hold,
    output logic        if_id_flush,
    output logic        id_ex_hold,
    output logic        id_ex_bubble,
    output logic        ex_mem_hold,
    output logic        mem_timeout,
`ifdef PIPE_HAZARD_PERF_EN
    input  logic        perf_clr,
    output logic [15:0] stall_count,
`endif
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        FLUSH      = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;

    logic load_use, mem_stall;
    logic hold_all, hold_front, flush, bubble, timeout_now;

    // Register 0 is hardwired, so a load targeting it can never create a hazard.
    assign load_use = ex_is_load & ex_reg_wen & (ex_rd != 5'd0) &
                      ((id_uses_top & (id_rs_top == ex_rd)) |
                       (id_uses_bot & (id_rs_bot == ex_rd)));
    assign mem_stall = mem_req & ~mem_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        hold_all    = 1'b0;
        hold_front  = 1'b0;
        flush       = 1'b0;
        bubble      = 1'b0;
        timeout_now = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    hold_all   = 1'b1;
                    wait_cnt_d = 8'd1;
                    state_d    = MEM_WAIT;
                end else if (branch_taken) begin
                    flush   = 1'b1;
                    bubble  = 1'b1;
                    state_d = FLUSH;
                end else if (load_use) begin
                    hold_front = 1'b1;
                    bubble     = 1'b1;
                    state_d    = LOAD_STALL;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = RUN;
                end else if (wait_cnt_q == 8'hFF) begin
                    timeout_now = 1'b1;
                    timeout_d   = 1'b1;
                    state_d     = RUN;
                end else begin
                    hold_all   = 1'b1;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            FLUSH: begin
                // The wrong-path fetch is squashed even if memory stalls this cycle.
                flush = 1'b1;
                if (mem_stall) begin
                    hold_all   = 1'b1;
                    wait_cnt_d = 8'd1;
                    state_d    = MEM_WAIT;
                end else begin
                    state_d = RUN;
                end
            end
            LOAD_STALL: begin
                if (mem_stall) begin
                    hold_all   = 1'b1;
                    wait_cnt_d = 8'd1;
                    state_d    = MEM_WAIT;
                end else begin
                    hold_front = 1'b1;
                    bubble     = 1'b1;
                    state_d    = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Outputs are gated by reset so they drop without waiting for a clock edge.
    assign pc_hold      = ~reset & (hold_all | hold_front);
    assign if_id_hold   = ~reset & (hold_all | hold_front);
    assign if_id_flush  = ~reset & flush;
    assign id_ex_hold   = ~reset & hold_all;
    assign id_ex_bubble = ~reset & bubble;
    assign ex_mem_hold  = ~reset & hold_all;
    assign mem_timeout  = ~reset & (timeout_q | timeout_now);
    assign state        = state_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (perf_clr) begin
            stall_cnt_d = 16'd0;
        end else if (pc_hold && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Self-checking bench for pipe_hazard_ctl: vector table, hand sequences, random vs. model.
module tb_pipe_hazard_ctl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  id_rs_top, id_rs_bot, ex_rd;
    logic        id_uses_top, id_uses_bot, ex_reg_wen, ex_is_load;
    logic        mem_req, mem_ready, branch_taken;
    logic        pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble, ex_mem_hold;
    logic        mem_timeout;
    logic [1:0]  state;
`ifdef PIPE_HAZARD_PERF_EN
    logic        perf_clr = 1'b0;
    logic [15:0] stall_count;
`endif

    pipe_hazard_ctl dut (
        .clock(clock), .reset(reset),
        .id_rs_top(id_rs_top), .id_rs_bot(id_rs_bot),
        .id_uses_top(id_uses_top), .id_uses_bot(id_uses_bot),
        .ex_rd(ex_rd), .ex_reg_wen(ex_reg_wen), .ex_is_load(ex_is_load),
        .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
        .id_ex_hold(id_ex_hold), .id_ex_bubble(id_ex_bubble), .ex_mem_hold(ex_mem_hold),
        .mem_timeout(mem_timeout),
`ifdef PIPE_HAZARD_PERF_EN
        .perf_clr(perf_clr), .stall_count(stall_count),
`endif
        .state(state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0] rt, rb, rd;
        logic       ut, ub, wen, ld, mreq, mrdy, br;
        logic [6:0] eo;   // {pc, if_id_hold, flush, id_ex_hold, bubble, ex_mem_hold, timeout}
        logic [1:0] es;
    } vec_t;

    localparam logic [6:0] H4 = 7'b1101010;
    localparam logic [6:0] LS = 7'b1100100;
    localparam logic [6:0] BR = 7'b0010100;
    localparam logic [6:0] FL = 7'b0010000;
    localparam logic [6:0] FM = 7'b1111010;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: how far into a memory wait we are, and which one-cycle follow-up is pending
    int m_wait = 0;
    bit m_flush = 0, m_lstall = 0, m_to = 0;
    int n_wait;
    bit n_flush, n_lstall, n_to;

    function automatic vec_t mk(logic [4:0] rt, logic [4:0] rb, logic ut, logic ub, logic [4:0] rd,
                                logic wen, logic ld, logic mreq, logic mrdy, logic br,
                                logic [6:0] eo, logic [1:0] es);
        vec_t v;
        v.rt = rt; v.rb = rb; v.ut = ut; v.ub = ub; v.rd = rd; v.wen = wen; v.ld = ld;
        v.mreq = mreq; v.mrdy = mrdy; v.br = br; v.eo = eo; v.es = es;
        return v;
    endfunction

    function automatic logic [6:0] outs();
        return {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble, ex_mem_hold, mem_timeout};
    endfunction

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
        end
    endtask

    task automatic set_in(input vec_t v);
        id_rs_top = v.rt; id_rs_bot = v.rb; id_uses_top = v.ut; id_uses_bot = v.ub;
        ex_rd = v.rd; ex_reg_wen = v.wen; ex_is_load = v.ld;
        mem_req = v.mreq; mem_ready = v.mrdy; branch_taken = v.br;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        set_in(mk(0,0,0,0,0,0,0,0,0,0,0,0));
        reset = 1'b1;
        #1;
        chk("reset_outs", 16'(outs()), 16'h0);
        chk("reset_state", 16'(state), 16'h0);
        tick();
        reset = 1'b0;
        m_wait = 0; m_flush = 0; m_lstall = 0; m_to = 0;
    endtask

    task automatic model_eval(input vec_t v, output logic [6:0] eo, output logic [1:0] es);
        bit ms, lu, hold4, fe, fl, bub, tonow;
        ms = v.mreq && !v.mrdy;
        lu = v.ld && v.wen && (v.rd != 0) && ((v.ut && v.rt == v.rd) || (v.ub && v.rb == v.rd));
        hold4 = 0; fe = 0; fl = 0; bub = 0; tonow = 0;
        n_wait = 0; n_flush = 0; n_lstall = 0; n_to = m_to;
        if (m_wait > 0) begin
            es = 2'd2;
            if (!v.mrdy) begin
                if (m_wait == 255) begin
                    tonow = 1; n_to = 1;
                end else begin
                    hold4 = 1; n_wait = m_wait + 1;
                end
            end
        end else begin
            es = m_flush ? 2'd3 : (m_lstall ? 2'd1 : 2'd0);
            fl = m_flush;
            if (ms) begin
                hold4 = 1; n_wait = 1;
            end else if (m_lstall) begin
                fe = 1; bub = 1;
            end else if (!m_flush) begin
                if (v.br) begin
                    fl = 1; bub = 1; n_flush = 1;
                end else if (lu) begin
                    fe = 1; bub = 1; n_lstall = 1;
                end
            end
        end
        eo = {hold4 | fe, hold4 | fe, fl, hold4, bub, hold4, m_to | tonow};
    endtask

    vec_t tbl[$];
    vec_t idle;

    initial begin
        logic [6:0] eo;
        logic [1:0] es;
        vec_t v;
        idle = mk(0,0,0,0,0,0,0,0,0,0,0,0);

        // load-use via top operand, then register 0, bottom operand, and non-hazards
        tbl.push_back(mk(3,0,1,0,3,1,1,0,0,0,LS,0));
        tbl.push_back(mk(3,0,1,0,3,1,1,0,0,0,LS,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,1,1,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,1,1,0,0,0,0,0));
        tbl.push_back(mk(0,7,0,1,7,1,1,0,0,0,LS,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,LS,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(5,0,0,0,5,1,1,0,0,0,0,0));
        tbl.push_back(mk(5,0,1,0,5,0,1,0,0,0,0,0));
        tbl.push_back(mk(5,0,1,0,5,1,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,1,0,0,0));
        // memory wait of four cycles
        tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,H4,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,H4,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,H4,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,H4,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,1,0,0,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0));
        // branch beats load-use; memory stall beats branch
        tbl.push_back(mk(3,0,1,0,3,1,1,0,0,1,BR,0));
        tbl.push_back(mk(3,0,1,0,3,1,1,0,0,1,FL,3));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,0,1,H4,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,1,1,0,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0));
        // memory stall arriving during FLUSH and during LOAD_STALL
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,BR,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,FM,3));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,1,0,0,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(9,0,1,0,9,1,1,0,0,0,LS,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,H4,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,1,0,0,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0));

        set_in(idle);
        #2;
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i]);
            @(negedge clock);
            chk($sformatf("tbl%0d_outs", i), 16'(outs()), 16'(tbl[i].eo));
            chk($sformatf("tbl%0d_state", i), 16'(state), 16'(tbl[i].es));
            tick();
        end

        // memory that never answers: holds drop on the 256th cycle with timeout, which sticks
        do_reset();
        set_in(mk(0,0,0,0,0,0,0,1,0,0,0,0));
        for (int c = 1; c <= 256; c++) begin
            @(negedge clock);
            if (c < 256) chk($sformatf("tmo_hold_c%0d", c), 16'(outs()), 16'(H4));
            else         chk("tmo_drop", 16'(outs()), 16'h0001);
            tick();
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            chk("tmo_sticky", 16'(mem_timeout), 16'h1);
            tick();
        end
        set_in(idle);
        @(negedge clock);
        chk("tmo_sticky_idle", 16'(mem_timeout), 16'h1);
        tick();
        do_reset();
        chk("tmo_cleared", 16'(mem_timeout), 16'h0);

        // reset asserted in the middle of a memory wait
        set_in(mk(0,0,0,0,0,0,0,1,0,0,0,0));
        repeat (3) tick();
        chk("mw_state_pre", 16'(state), 16'h2);
        #2;
        reset = 1'b1;
        #1;
        chk("mw_rst_outs", 16'(outs()), 16'h0);
        chk("mw_rst_state", 16'(state), 16'h0);
        tick();
        reset = 1'b0;
        set_in(idle);
        @(negedge clock);
        chk("mw_after_state", 16'(state), 16'h0);
        chk("mw_after_outs", 16'(outs()), 16'h0);
        tick();

        // reset asserted in the middle of a flush
        set_in(mk(0,0,0,0,0,0,0,0,0,1,0,0));
        tick();
        chk("fl_state_pre", 16'(state), 16'h3);
        #2;
        reset = 1'b1;
        #1;
        chk("fl_rst_outs", 16'(outs()), 16'h0);
        chk("fl_rst_state", 16'(state), 16'h0);
        tick();
        reset = 1'b0;
        set_in(idle);
        @(negedge clock);
        chk("fl_after_state", 16'(state), 16'h0);
        tick();

        // random traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            v.rt = 5'($urandom_range(0, 3));
            v.rb = 5'($urandom_range(0, 3));
            v.rd = 5'($urandom_range(0, 3));
            v.ut = 1'($urandom_range(0, 1));
            v.ub = 1'($urandom_range(0, 1));
            v.wen = 1'($urandom_range(0, 1));
            v.ld = 1'($urandom_range(0, 1));
            v.mreq = ($urandom_range(0, 3) == 0);
            v.mrdy = 1'($urandom_range(0, 1));
            v.br = ($urandom_range(0, 5) == 0);
            v.eo = 7'd0; v.es = 2'd0;
            set_in(v);
            model_eval(v, eo, es);
            @(negedge clock);
            chk($sformatf("rnd%0d_outs", i), 16'(outs()), 16'(eo));
            chk($sformatf("rnd%0d_state", i), 16'(state), 16'(es));
            chk("rnd_hold_bubble_excl", 16'(id_ex_hold & id_ex_bubble), 16'h0);
            tick();
            m_wait = n_wait; m_flush = n_flush; m_lstall = n_lstall; m_to = n_to;
        end

`ifdef PIPE_HAZARD_PERF_EN
        do_reset();
        chk("perf_reset", stall_count, 16'h0);
        set_in(mk(0,0,0,0,0,0,0,1,0,0,0,0));
        repeat (5) tick();
        chk("perf_five", stall_count, 16'd5);
        perf_clr = 1'b1;
        tick();
        chk("perf_clr", stall_count, 16'h0);
        perf_clr = 1'b0;
        repeat (67000) tick();
        chk("perf_sat", stall_count, 16'hFFFF);
        repeat (3) tick();
        chk("perf_sat_hold", stall_count, 16'hFFFF);
        perf_clr = 1'b1;
        tick();
        chk("perf_clr_sat", stall_count, 16'h0);
        perf_clr = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
